// File: rtl/decimal_key_debouncer_if.sv
// Bundles the raw key lines and the debounced outputs of the decimal
// key debouncer. The master side drives key_raw (keypad / bench), the
// slave side is the debouncer itself.
interface decimal_key_debouncer_if;
   logic [9:0] key_raw;
   logic [9:0] d_out;
   logic       key_strobe;
   logic       multi_err;
   logic       busy;

   modport master (
      output key_raw,
      input  d_out,
      input  key_strobe,
      input  multi_err,
      input  busy
   );

   modport slave (
      input  key_raw,
      output d_out,
      output key_strobe,
      output multi_err,
      output busy
   );
endinterface

// File: rtl/decimal_key_debouncer.sv
// Debounces ten active-high decimal key lines and presents the accepted
// digit as a registered one-hot word for a decimal-to-binary encoder.
// A press is accepted after DEBOUNCE_CYCLES identical nonzero samples,
// a release after DEBOUNCE_CYCLES consecutive all-zero samples.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no key seen; waiting for any nonzero synchronized sample
// ST_DEBOUNCE | counting identical nonzero samples of the captured pattern
// ST_HELD     | pattern accepted (or rejected as multi-key); waiting for zero
// ST_RELEASE  | counting consecutive all-zero samples before going idle
module decimal_key_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   decimal_key_debouncer_if.slave kif
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   // cnt counts samples already seen in the current run, so the run is
   // complete when it reaches DEBOUNCE_CYCLES-1 and the new sample matches.
   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [9:0]  key_meta;
   logic [9:0]  key_sync;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [9:0]  sample;
   logic [9:0]  sample_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic [9:0]  d_out_q;
   logic [9:0]  d_out_nxt;
   logic        strobe_q;
   logic        strobe_nxt;
   logic        err_q;
   logic        err_nxt;

   logic        key_any;
   logic        key_same;
   logic        sample_onehot;
   logic        run_done;

   // Two-flop synchronizer; only key_sync is used beyond this point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= '0;
         key_sync <= '0;
      end else begin
         key_meta <= kif.key_raw;
         key_sync <= key_meta;
      end
   end

   assign key_any       = (key_sync != 10'd0);
   assign key_same      = (key_sync == sample);
   assign sample_onehot = (sample != 10'd0) && ((sample & (sample - 10'd1)) == 10'd0);
   assign run_done      = (cnt >= CNT_LAST);

   // Next-state, counter and output decisions for the press/release FSM.
   always_comb begin
      state_nxt  = state;
      sample_nxt = sample;
      cnt_nxt    = cnt;
      d_out_nxt  = d_out_q;
      strobe_nxt = 1'b0;
      err_nxt    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (key_any) begin
               sample_nxt = key_sync;
               cnt_nxt    = 16'd1;
               state_nxt  = ST_DEBOUNCE;
            end
         end

         ST_DEBOUNCE: begin
            if (!key_any) begin
               state_nxt = ST_IDLE;
            end else if (!key_same) begin
               sample_nxt = key_sync;
               cnt_nxt    = 16'd1;
            end else if (!run_done) begin
               cnt_nxt = cnt + 16'd1;
            end else begin
               state_nxt = ST_HELD;
               if (sample_onehot) begin
                  d_out_nxt  = sample;
                  strobe_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end

         // Extra or different keys while held are deliberately ignored.
         ST_HELD: begin
            if (!key_any) begin
               cnt_nxt   = 16'd1;
               state_nxt = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (key_any) begin
               state_nxt = ST_HELD;
            end else if (!run_done) begin
               cnt_nxt = cnt + 16'd1;
            end else begin
               d_out_nxt = 10'd0;
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            d_out_nxt = 10'd0;
         end
      endcase
   end

   // FSM state, sample/counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         sample   <= '0;
         cnt      <= '0;
         d_out_q  <= '0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         sample   <= sample_nxt;
         cnt      <= cnt_nxt;
         d_out_q  <= d_out_nxt;
         strobe_q <= strobe_nxt;
         err_q    <= err_nxt;
      end
   end

   assign kif.d_out      = d_out_q;
   assign kif.key_strobe = strobe_q;
   assign kif.multi_err  = err_q;
   assign kif.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Directed scenarios followed by random key traffic, all compared every
// cycle against a run-length reference model of the debouncer behaviour.
module tb_decimal_key_debouncer;

   localparam int DC = 4;

   logic clk;
   logic rst_n;

   decimal_key_debouncer_if kif();

   decimal_key_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int st_cnt   = 0;

   // Reference model: keys reach the decision logic two edges after being
   // driven; a press is a run of DC equal nonzero samples, a release a run
   // of DC zero samples.
   logic [9:0] m_s1, m_s2, m_ks, m_runv, m_d;
   int         m_run;
   bit         m_pressed, m_strobe, m_err, m_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_runv = '0; m_d = '0;
         m_run = 0; m_pressed = 0; m_strobe = 0; m_err = 0; m_busy = 0;
      end else begin
         m_ks = m_s2;
         m_s2 = m_s1;
         m_s1 = kif.key_raw;
         m_strobe = 0;
         m_err = 0;
         if (!m_pressed) begin
            if (m_ks == 0) m_run = 0;
            else if (m_run > 0 && m_ks == m_runv) m_run++;
            else begin m_run = 1; m_runv = m_ks; end
            if (m_run == DC) begin
               m_pressed = 1;
               m_run = 0;
               if ($countones(m_runv) == 1) begin m_d = m_runv; m_strobe = 1; end
               else m_err = 1;
            end
         end else begin
            if (m_ks == 0) m_run++;
            else m_run = 0;
            if (m_run == DC) begin
               m_pressed = 0;
               m_run = 0;
               m_d = '0;
            end
         end
         m_busy = m_pressed || (m_run > 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("d_out",      32'(kif.d_out),      32'(m_d));
      chk("key_strobe", 32'(kif.key_strobe), 32'(m_strobe));
      chk("multi_err",  32'(kif.multi_err),  32'(m_err));
      chk("busy",       32'(kif.busy),       32'(m_busy));
      chk("exclusive",  32'(kif.key_strobe & kif.multi_err), 32'd0);
      chk("onehot0",    32'($countones(kif.d_out) <= 1), 32'd1);
      if (kif.key_strobe) st_cnt++;
   endtask

   task automatic run(input logic [9:0] raw, input int n);
      for (int i = 0; i < n; i++) begin
         kif.key_raw = raw;
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      logic [9:0] val;
      int         r;
      int         len;

      rst_n = 1'b0;
      kif.key_raw = '0;
      repeat (3) @(negedge clk);
      chk("rst_d_out",  32'(kif.d_out), 32'd0);
      chk("rst_strobe", 32'(kif.key_strobe), 32'd0);
      chk("rst_err",    32'(kif.multi_err), 32'd0);
      chk("rst_busy",   32'(kif.busy), 32'd0);
      rst_n = 1'b1;

      // Clean press of digit 7, long hold, release.
      st_cnt = 0;
      run(10'h080, 5);
      chk("press_early", 32'(kif.d_out), 32'd0);
      run(10'h080, 1);
      chk("press_strobe", 32'(kif.key_strobe), 32'd1);
      chk("press_d_out",  32'(kif.d_out), 32'h080);
      run(10'h080, 20);
      chk("hold_one_strobe", 32'(st_cnt), 32'd1);
      run(10'h000, 5);
      chk("release_early", 32'(kif.d_out), 32'h080);
      run(10'h000, 1);
      chk("release_d_out", 32'(kif.d_out), 32'd0);
      run(10'h000, 2);

      // Bouncing digit 3, then a one-cycle glitch on digit 5.
      st_cnt = 0;
      run(10'h008, 1); run(10'h000, 1); run(10'h008, 2); run(10'h000, 1);
      run(10'h008, 5);
      chk("bounce_no_strobe", 32'(st_cnt), 32'd0);
      run(10'h008, 1);
      chk("bounce_strobe", 32'(kif.key_strobe), 32'd1);
      chk("bounce_d_out",  32'(kif.d_out), 32'h008);
      run(10'h000, 8);
      st_cnt = 0;
      run(10'h020, 1);
      run(10'h000, 8);
      chk("glitch_busy",   32'(kif.busy), 32'd0);
      chk("glitch_strobe", 32'(st_cnt), 32'd0);

      // Two keys at once.
      st_cnt = 0;
      run(10'h024, 5);
      chk("multi_early", 32'(kif.multi_err), 32'd0);
      run(10'h024, 1);
      chk("multi_err",    32'(kif.multi_err), 32'd1);
      chk("multi_d_out",  32'(kif.d_out), 32'd0);
      chk("multi_strobe", 32'(st_cnt), 32'd0);
      run(10'h024, 4);
      run(10'h000, 5);
      chk("multi_rel_busy_hi", 32'(kif.busy), 32'd1);
      run(10'h000, 1);
      chk("multi_rel_busy_lo", 32'(kif.busy), 32'd0);

      // Second key added while digit 1 held, then digit 9 alone.
      run(10'h002, 6);
      chk("held1_d_out", 32'(kif.d_out), 32'h002);
      st_cnt = 0;
      run(10'h202, 10);
      chk("held_extra_d_out",  32'(kif.d_out), 32'h002);
      chk("held_extra_strobe", 32'(st_cnt), 32'd0);
      run(10'h000, 8);
      run(10'h200, 6);
      chk("digit9_d_out",  32'(kif.d_out), 32'h200);
      chk("digit9_strobe", 32'(st_cnt), 32'd1);

      // Release bounce on digit 0.
      run(10'h000, 8);
      run(10'h001, 6);
      st_cnt = 0;
      run(10'h000, 3); run(10'h001, 1); run(10'h000, 5);
      chk("relbounce_hold",   32'(kif.d_out), 32'h001);
      chk("relbounce_strobe", 32'(st_cnt), 32'd0);
      run(10'h000, 1);
      chk("relbounce_clear", 32'(kif.d_out), 32'd0);

      // Asynchronous reset while digit 4 is held.
      run(10'h000, 4);
      run(10'h010, 6);
      chk("pre_reset_d_out", 32'(kif.d_out), 32'h010);
      #2 rst_n = 1'b0;
      #1;
      chk("async_d_out",  32'(kif.d_out), 32'd0);
      chk("async_strobe", 32'(kif.key_strobe), 32'd0);
      chk("async_err",    32'(kif.multi_err), 32'd0);
      chk("async_busy",   32'(kif.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(10'h010, 5);
      chk("rearm_early", 32'(kif.d_out), 32'd0);
      run(10'h010, 1);
      chk("rearm_strobe", 32'(kif.key_strobe), 32'd1);
      chk("rearm_d_out",  32'(kif.d_out), 32'h010);
      run(10'h000, 8);

      // Random key traffic.
      for (int seg = 0; seg < 200; seg++) begin
         r = int'($urandom_range(0, 99));
         if (r < 45)      val = 10'd0;
         else if (r < 85) val = 10'(1 << $urandom_range(0, 9));
         else             val = 10'($urandom);
         len = int'($urandom_range(1, 10));
         run(val, len);
      end
      run(10'h000, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
